// File: rtl/booth_pkg.sv
// Shared definitions for the Booth pipeline stage.
// Holds default widths, the Booth state grouping carried between stages and
// the skid-buffer state encodings.
package booth_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;
    localparam int TAG_W = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic [WIDTH-1:0] acc;
        logic [WIDTH-1:0] q;
        logic             qm1;
        logic [WIDTH-1:0] mcand;
        logic [CNT_W-1:0] cnt;
        logic [TAG_W-1:0] tag;
    } booth_state_t;

endpackage

// File: rtl/booth_step_chain.sv
// Combinational chain of STEPS Booth substeps. Link i applies its substep
// only when en[i] is set; disabled links forward their input state.
// Ports:
//   en                  - per-link enable, contiguous from bit 0
//   acc, q, qm1, mcand  - incoming state
//   acc_out, q_out, qm1_out - state after the enabled links
module booth_step_chain
    import booth_pkg::*;
#(
    parameter int STEPS = 4
) (
    input  logic [STEPS-1:0] en,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic             qm1,
    input  logic [WIDTH-1:0] mcand,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] q_out,
    output logic             qm1_out
);

    logic [WIDTH-1:0] acc_l [0:STEPS];
    logic [WIDTH-1:0] q_l   [0:STEPS];
    logic             qm1_l [0:STEPS];

    assign acc_l[0] = acc;
    assign q_l[0]   = q;
    assign qm1_l[0] = qm1;

    for (genvar i = 0; i < STEPS; i++) begin : g_link
        booth_substep u_sub (
            .en       (en[i]),
            .acc      (acc_l[i]),
            .q        (q_l[i]),
            .qm1      (qm1_l[i]),
            .mcand    (mcand),
            .acc_next (acc_l[i+1]),
            .q_next   (q_l[i+1]),
            .qm1_next (qm1_l[i+1])
        );
    end

    assign acc_out = acc_l[STEPS];
    assign q_out   = q_l[STEPS];
    assign qm1_out = qm1_l[STEPS];

endmodule

// File: rtl/booth_substep.sv
// One radix-2 Booth substep on {A, Q, q-1}; passes the state through when
// en is low. Fixed at booth_pkg::WIDTH bits.
// Ports:
//   en                  - apply the substep (1) or forward unchanged (0)
//   acc, q, qm1, mcand  - current state and multiplicand
//   acc_next, q_next, qm1_next - resulting state
module booth_substep
    import booth_pkg::*;
(
    input  logic             en,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic             qm1,
    input  logic [WIDTH-1:0] mcand,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] q_next,
    output logic             qm1_next
);

    logic [WIDTH-1:0] t;

    always_comb begin
        if (q[0] == qm1)
            t = acc;
        else if (q[0])
            t = acc - mcand;
        else
            t = acc + mcand;

        if (en) begin
            acc_next = {t[WIDTH-1], t[WIDTH-1:1]};
            q_next   = {t[0], q[WIDTH-1:1]};
            qm1_next = q[0];
        end else begin
            acc_next = acc;
            q_next   = q;
            qm1_next = qm1;
        end
    end

endmodule

// File: rtl/booth_pipe_stage.sv
// Registered Booth multiplier pipeline stage with a 2-entry skid buffer.
// Applies up to STEPS substeps per pass, clamped so the count never exceeds
// WIDTH; counts at or above WIDTH bypass the chain.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid / in_ready   - upstream handshake (in_ready is registered)
//   in_acc..in_tag        - incoming Booth state
//   out_valid / out_ready - downstream handshake
//   out_acc..out_tag      - registered Booth state
//   out_done              - out_cnt == WIDTH, {out_acc, out_q} is the product
//
// state | meaning
// EMPTY | no entries, in_ready=1, out_valid=0
// ONE   | output register holds an entry, in_ready=1
// FULL  | output and skid registers hold entries, in_ready=0
module booth_pipe_stage #(
    parameter int WIDTH = 32,
    parameter int STEPS = 4,
    parameter int TAG_W = 4,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_acc,
    input  logic [WIDTH-1:0] in_q,
    input  logic             in_qm1,
    input  logic [WIDTH-1:0] in_mcand,
    input  logic [CNT_W-1:0] in_cnt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic [WIDTH-1:0] out_q,
    output logic             out_qm1,
    output logic [WIDTH-1:0] out_mcand,
    output logic [CNT_W-1:0] out_cnt,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_done
);

    import booth_pkg::*;

    localparam int CW = CNT_W + 1;

    skid_state_t  state_q, state_d;
    logic         in_ready_q;
    logic         load_out, load_skid, skid_to_out;
    logic         in_xfer, out_xfer;
    booth_state_t out_r, skid_r, stage_res;

    logic [CW-1:0]    rem, n_steps;
    logic [STEPS-1:0] link_en;
    logic [WIDTH-1:0] acc_res, q_res;
    logic             qm1_res;

    // Steps still needed, clamped to STEPS; zero when already at or past WIDTH.
    always_comb begin
        rem     = '0;
        n_steps = '0;
        if (in_cnt < CNT_W'(WIDTH)) begin
            rem     = CW'(WIDTH) - {1'b0, in_cnt};
            n_steps = (rem < CW'(STEPS)) ? rem : CW'(STEPS);
        end
        for (int i = 0; i < STEPS; i++)
            link_en[i] = CW'(i) < n_steps;
    end

    booth_step_chain #(.STEPS(STEPS)) u_chain (
        .en      (link_en),
        .acc     (in_acc),
        .q       (in_q),
        .qm1     (in_qm1),
        .mcand   (in_mcand),
        .acc_out (acc_res),
        .q_out   (q_res),
        .qm1_out (qm1_res)
    );

    always_comb begin
        stage_res.acc   = acc_res;
        stage_res.q     = q_res;
        stage_res.qm1   = qm1_res;
        stage_res.mcand = in_mcand;
        stage_res.cnt   = in_cnt + n_steps[CNT_W-1:0];
        stage_res.tag   = in_tag;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign in_xfer   = in_valid && in_ready_q;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    load_out = 1'b1;
                    state_d  = ONE;
                end
            end
            ONE: begin
                if (in_xfer && !out_xfer) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end else if (!in_xfer && out_xfer) begin
                    state_d = EMPTY;
                end else if (in_xfer && out_xfer) begin
                    load_out = 1'b1;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    skid_to_out = 1'b1;
                    state_d     = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
            out_r      <= '0;
            skid_r     <= '0;
        end else begin
            state_q    <= state_d;
            // Registered from next state so out_ready never reaches in_ready combinationally.
            in_ready_q <= (state_d != FULL);
            if (load_out)
                out_r <= stage_res;
            else if (skid_to_out)
                out_r <= skid_r;
            if (load_skid)
                skid_r <= stage_res;
        end
    end

    assign out_acc   = out_r.acc;
    assign out_q     = out_r.q;
    assign out_qm1   = out_r.qm1;
    assign out_mcand = out_r.mcand;
    assign out_cnt   = out_r.cnt;
    assign out_tag   = out_r.tag;
    assign out_done  = (out_r.cnt == CNT_W'(WIDTH));

endmodule

// File: doc/booth_pipe_stage.md
Name: booth_pipe_stage

Overview:
- Registered pipeline stage of the Booth_Pipeline_v2 multiplier.
- Accepts a partial Booth state {acc, Q, q-1, multiplicand, step count, tag} with a valid/ready handshake.
- Applies up to STEPS radix-2 Booth substeps combinationally, then registers the result into a 2-entry skid buffer.
- Instances are cascaded (WIDTH/STEPS deep) between the operand loader and the product collector. Stage k's output feeds stage k+1's input.

Parameters:
- WIDTH, 32, operand width. acc, Q and multiplicand are WIDTH bits.
- STEPS, 4, maximum Booth substeps applied per stage. Legal range 1..WIDTH.
- TAG_W, 4, width of the opaque transaction tag carried alongside the data.
- CNT_W, 6, step-counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream presents a state
- in_ready  out  1  stage can accept; registered output
- in_acc  in  WIDTH  accumulator (signed)
- in_q  in  WIDTH  Q register (multiplier / low product half)
- in_qm1  in  1  q-1 bit
- in_mcand  in  WIDTH  multiplicand (signed)
- in_cnt  in  CNT_W  substeps already completed
- in_tag  in  TAG_W  transaction tag
- out_valid  out  1  registered state available
- out_ready  in  1  downstream accepts
- out_acc  out  WIDTH  next accumulator
- out_q  out  WIDTH  next Q
- out_qm1  out  1  next q-1
- out_mcand  out  WIDTH  multiplicand, forwarded unchanged
- out_cnt  out  CNT_W  in_cnt plus the number of steps applied
- out_tag  out  TAG_W  forwarded tag
- out_done  out  1  out_cnt == WIDTH; {out_acc, out_q} is the final 2*WIDTH-bit product

Behaviour:
- Reset:
  - out_valid=0, in_ready=0 while rst is high; in_ready=1 on the first cycle after rst deasserts.
  - All data outputs and both buffer entries are 0. Skid state = EMPTY.
- Substep definition, applied to {A, Q, q-1}:
  - If Q[0]==q-1, T=A.
  - Else T = A-M when Q[0]=1, T = A+M when Q[0]=0. Arithmetic is WIDTH-bit two's complement and wraps.
  - Next state: A' = T>>>1 (sign-extended), Q' = {T[0], Q[WIDTH-1:1]}, q-1' = Q[0].
- Step count:
  - n = min(STEPS, WIDTH - in_cnt) when in_cnt < WIDTH, otherwise n = 0 (bypass).
  - Substeps beyond n pass their state through unchanged.
  - out_cnt = in_cnt + n, never exceeding WIDTH.
  - in_cnt > WIDTH is treated as bypass, with the count forwarded unchanged.
- Handshake:
  - A transfer occurs when valid && ready on the same edge.
  - in_ready depends only on registered state: no combinational path from out_ready to in_ready.
  - Data is held stable while out_valid && !out_ready.
- Skid FSM:
  - States: EMPTY (in_ready=1, out_valid=0), ONE (in_ready=1, out_valid=1), FULL (in_ready=0, out_valid=1).
  - EMPTY --in xfer--> ONE.
  - ONE --in xfer && !out xfer--> FULL; the new entry goes to the skid register.
  - ONE --out xfer && !in xfer--> EMPTY.
  - ONE --both--> ONE; the output register is loaded with the new entry.
  - FULL --out xfer--> ONE; the skid entry moves to the output register.
  - In FULL, in_valid is ignored.
- Latency and throughput: one cycle input-to-output; sustained one transfer per cycle when out_ready=1.
- Ordering is strictly FIFO.
- Reset asserted mid-operation: in-flight entries are discarded without being emitted; state returns to EMPTY on the next edge.

Decomposition:
- Package booth_pkg holds:
  - WIDTH and CNT_W defaults;
  - a booth_state_t-equivalent field grouping (acc, q, qm1, mcand, cnt, tag);
  - skid state encodings EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
- Sub-module booth_step_chain holds the combinational STEPS-deep generate chain of existing booth_substep instances.
  - Each link has a per-link enable (link i is active when i < n).
  - It is only valid for WIDTH=32 unless booth_substep is widened.
- booth_pipe_stage contains only the enable computation, the skid FSM and the registers.

Test Plan:
- Single stage, STEPS=4: acc=0, q=5, qm1=0, mcand=3, cnt=0 -> one cycle later out_acc=0x00000000, out_q=0xF0000000, out_qm1=0, out_cnt=4, out_done=0.
- 8 cascaded stages, out_ready=1, operands 3×5 -> after 8 cycles out_acc=0x00000000, out_q=0x0000000F, out_done=1. Operands -7×6 -> out_acc=0xFFFFFFFF, out_q=0xFFFFFFD6.
- Clamp: in_cnt=30 with STEPS=4 -> exactly 2 substeps applied, out_cnt=32, out_done=1. Bypass: in_cnt=32 -> data unchanged, out_cnt=32.
- Backpressure: 4 back-to-back inputs (tags 1..4) with out_ready held 0 -> in_ready drops after the 2nd acceptance and tag 1 is held. Releasing out_ready -> tags emerge 1,2,3,4 in order, none lost or duplicated, full rate once streaming.
- Random valid/ready toggling over 1000 transactions -> every product matches the reference model $signed(a)*$signed(b), order preserved.
- Reset in FULL state -> next cycle out_valid=0, in_ready=0 while rst is high, then 1. No stale tag is emitted afterwards.
